camera_pattern_tx: RTL and testbench

Synthetic OV7670-style camera source for the FPGA vision pipeline. It drives PCLK, VSYNC, HREF and an 8-bit data bus carrying RGB565 test patterns at QCIF resolution, emitting two bytes per pixel. It has two uses: bench stimulus for the camera capture path, and an on-board loopback source wired to the GPIO_1 camera header in place of the real sensor. It transmits the same interface the capture block receives.

---
 rtl/camera_pattern_tx_pkg.sv | 50 +++++
 rtl/cam_pattern_color.sv | 33 +++
 rtl/camera_pattern_tx.sv | 152 +++++++++++++++
 tb/tb_camera_pattern_tx.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/camera_pattern_tx_pkg.sv
// Shared definitions for the synthetic camera source: RGB565 colours, pattern
// encodings, default QCIF timing (also used by the capture block) and FSM states.
package camera_pattern_tx_pkg;

  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  localparam int QCIF_WIDTH        = 176;
  localparam int QCIF_HEIGHT       = 144;
  localparam int DEF_H_BLANK       = 16;
  localparam int DEF_VSYNC_LINES   = 3;
  localparam int DEF_V_BACK_LINES  = 2;
  localparam int DEF_V_FRONT_LINES = 2;

  typedef enum logic [1:0] {
    PAT_RED   = 2'd0,
    PAT_BLUE  = 2'd1,
    PAT_BARS  = 2'd2,
    PAT_CHECK = 2'd3
  } pattern_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_VSYNC, ST_VBACK, ST_ACTIVE, ST_VFRONT
  } state_e;

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

  // Bars run white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [15:0] bar_color(logic [2:0] idx);
    case (idx)
      3'd0:    return RGB_WHITE;
      3'd1:    return RGB_YELLOW;
      3'd2:    return RGB_CYAN;
      3'd3:    return RGB_GREEN;
      3'd4:    return RGB_MAGENTA;
      3'd5:    return RGB_RED;
      3'd6:    return RGB_BLUE;
      default: return RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/cam_pattern_color.sv
// Combinational RGB565 pixel generator for the selected test pattern.
module cam_pattern_color
  import camera_pattern_tx_pkg::*;
#(
  parameter int X_W = 8,
  parameter int Y_W = 8
) (
  input  pattern_e         pattern,
  input  logic [X_W-1:0]   x,
  input  logic [Y_W-1:0]   y,
  input  logic [2:0]       bar_idx,
  output logic [15:0]      rgb
);

  logic [X_W-1:0] x_tile;
  logic [Y_W-1:0] y_tile;

  // 16x16 tiles: parity of the tile coordinates picks the colour.
  assign x_tile = x >> 4;
  assign y_tile = y >> 4;

  always_comb begin
    rgb = RGB_RED;
    case (pattern)
      PAT_RED:   rgb = RGB_RED;
      PAT_BLUE:  rgb = RGB_BLUE;
      PAT_BARS:  rgb = bar_color(bar_idx);
      PAT_CHECK: rgb = (x_tile[0] ^ y_tile[0]) ? RGB_BLUE : RGB_RED;
      default:   rgb = RGB_RED;
    endcase
  end

endmodule

// File: rtl/camera_pattern_tx.sv
// OV7670-style camera source: PCLK = clk/2, VSYNC/HREF/DATA change on PCLK falls,
// two RGB565 bytes per pixel, frames repeat while en is high.
module camera_pattern_tx
  import camera_pattern_tx_pkg::*;
#(
  parameter int WIDTH         = QCIF_WIDTH,
  parameter int HEIGHT        = QCIF_HEIGHT,
  parameter int H_BLANK       = DEF_H_BLANK,
  parameter int VSYNC_LINES   = DEF_VSYNC_LINES,
  parameter int V_BACK_LINES  = DEF_V_BACK_LINES,
  parameter int V_FRONT_LINES = DEF_V_FRONT_LINES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] pattern,
  output logic       pclk,
  output logic       vsync,
  output logic       href,
  output logic [7:0] data,
  output logic       frame_done
);

  localparam int LINE      = 2 * WIDTH + H_BLANK;
  localparam int BYTE_W    = $clog2(LINE);
  localparam int MAX_LINES = max2(max2(HEIGHT, VSYNC_LINES), max2(V_BACK_LINES, V_FRONT_LINES));
  localparam int LINE_W    = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;
  localparam int X_W       = $clog2(WIDTH);
  localparam int Y_W       = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int BAR_PIX   = WIDTH / 8;
  localparam int BAR_W     = (BAR_PIX > 1) ? $clog2(BAR_PIX) : 1;

  state_e              state, state_n;
  pattern_e            pat_q, pat_n;
  logic [BYTE_W-1:0]   byte_cnt, byte_n;
  logic [LINE_W-1:0]   line_cnt, line_n;
  logic [BAR_W-1:0]    bar_pix, bar_pix_n;
  logic [2:0]          bar_idx, bar_idx_n;
  logic                done_n, vsync_n, href_n;
  logic [7:0]          data_n;
  logic [15:0]         rgb;

  function automatic logic [LINE_W-1:0] phase_last(state_e s);
    case (s)
      ST_VSYNC:  return LINE_W'(VSYNC_LINES - 1);
      ST_VBACK:  return LINE_W'(V_BACK_LINES - 1);
      ST_ACTIVE: return LINE_W'(HEIGHT - 1);
      ST_VFRONT: return LINE_W'(V_FRONT_LINES - 1);
      default:   return '0;
    endcase
  endfunction

  // Next position in the frame; outputs are derived from the next position so
  // they appear on the very fall tick that enters it.
  always_comb begin
    state_n   = state;
    pat_n     = pat_q;
    byte_n    = byte_cnt;
    line_n    = line_cnt;
    bar_pix_n = bar_pix;
    bar_idx_n = bar_idx;
    done_n    = 1'b0;
    if (state == ST_IDLE) begin
      byte_n = '0;
      line_n = '0;
      if (en) begin
        state_n = ST_VSYNC;
        pat_n   = pattern_e'(pattern);
      end
    end else if (byte_cnt == BYTE_W'(LINE - 1)) begin
      byte_n = '0;
      if (line_cnt == phase_last(state)) begin
        line_n = '0;
        case (state)
          ST_VSYNC:  state_n = ST_VBACK;
          ST_VBACK:  state_n = ST_ACTIVE;
          ST_ACTIVE: state_n = ST_VFRONT;
          default: begin
            done_n  = 1'b1;
            state_n = en ? ST_VSYNC : ST_IDLE;
            if (en) pat_n = pattern_e'(pattern);
          end
        endcase
      end else begin
        line_n = line_cnt + 1'b1;
      end
    end else begin
      byte_n = byte_cnt + 1'b1;
    end

    // Bar index advances by counting pixels within the current bar.
    if (byte_n == '0) begin
      bar_pix_n = '0;
      bar_idx_n = '0;
    end else if (!byte_n[0]) begin
      if (bar_pix == BAR_W'(BAR_PIX - 1)) begin
        bar_pix_n = '0;
        bar_idx_n = bar_idx + 3'd1;
      end else begin
        bar_pix_n = bar_pix + 1'b1;
      end
    end

    vsync_n = (state_n == ST_VSYNC);
    href_n  = (state_n == ST_ACTIVE) && (byte_n < BYTE_W'(2 * WIDTH));
    data_n  = 8'h00;
    if (href_n) data_n = byte_n[0] ? rgb[7:0] : rgb[15:8];
  end

  cam_pattern_color #(
    .X_W(X_W),
    .Y_W(Y_W)
  ) u_color (
    .pattern (pat_n),
    .x       (X_W'(byte_n >> 1)),
    .y       (Y_W'(line_n)),
    .bar_idx (bar_idx_n),
    .rgb     (rgb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pat_q      <= PAT_RED;
      byte_cnt   <= '0;
      line_cnt   <= '0;
      bar_pix    <= '0;
      bar_idx    <= '0;
      pclk       <= 1'b0;
      vsync      <= 1'b0;
      href       <= 1'b0;
      data       <= 8'h00;
      frame_done <= 1'b0;
    end else begin
      pclk       <= ~pclk;
      frame_done <= 1'b0;
      if (pclk) begin
        state      <= state_n;
        pat_q      <= pat_n;
        byte_cnt   <= byte_n;
        line_cnt   <= line_n;
        bar_pix    <= bar_pix_n;
        bar_idx    <= bar_idx_n;
        vsync      <= vsync_n;
        href       <= href_n;
        data       <= data_n;
        frame_done <= done_n;
      end
    end
  end

endmodule

// File: tb/tb_camera_pattern_tx.sv
// Bench for camera_pattern_tx on a reduced frame: a PCLK-rising receiver model
// captures each frame, which is compared against a pixel-rule reference.
module tb_camera_pattern_tx;

  localparam int W     = 32;
  localparam int H     = 20;
  localparam int HB    = 4;
  localparam int VS    = 3;
  localparam int VB    = 2;
  localparam int VF    = 2;
  localparam int LINE  = 2 * W + HB;
  localparam int FRAME_CLK = 2 * LINE * (VS + VB + H + VF);

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] pattern;
  logic       pclk, vsync, href, frame_done;
  logic [7:0] data;

  camera_pattern_tx #(
    .WIDTH(W), .HEIGHT(H), .H_BLANK(HB),
    .VSYNC_LINES(VS), .V_BACK_LINES(VB), .V_FRONT_LINES(VF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pattern(pattern),
    .pclk(pclk), .vsync(vsync), .href(href), .data(data), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: pixel colour straight from the pattern rules.
  function automatic logic [15:0] model_rgb(int pat, int x, int y);
    logic [15:0] bars [8];
    bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    case (pat)
      0:       return 16'hF800;
      1:       return 16'h001F;
      2:       return bars[x / (W / 8)];
      default: return ((((x >> 4) ^ (y >> 4)) & 1) != 0) ? 16'h001F : 16'hF800;
    endcase
  endfunction

  // Receiver model sampling at PCLK rise.
  logic [7:0] cap [H][2*W];
  int cyc = 0, done_cnt = 0, last_done = 0, prev_done = 0;
  int vs_rise = 0, vs_cnt = 0, mon_row = 0, col = 0, rows_seen = 0;
  int bad_rowlen = 0, blank_bad = 0, href_hi = 0, frame_pat = 0;
  logic prev_pclk = 1'b0, prev_vs = 1'b0, prev_href = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (frame_done) begin
      done_cnt++;
      prev_done = last_done;
      last_done = cyc;
    end
    if (pclk && !prev_pclk) begin
      if (vsync && !prev_vs) begin
        vs_rise++;
        mon_row = 0; col = 0; vs_cnt = 0; rows_seen = 0;
        bad_rowlen = 0; blank_bad = 0;
        frame_pat = int'(pattern);
      end
      if (vsync) vs_cnt++;
      if (href) begin
        if (mon_row < H && col < 2 * W) cap[mon_row][col] = data;
        col++;
        href_hi++;
      end else begin
        if (prev_href) begin
          rows_seen++;
          if (col != 2 * W) bad_rowlen++;
          mon_row++;
          col = 0;
        end
        if (data != 8'h00) blank_bad++;
      end
      prev_vs   = vsync;
      prev_href = href;
    end
    prev_pclk = pclk;
  end

  typedef struct {
    int         pat;
    int         x;
    int         y;
    logic [7:0] b0;
    logic [7:0] b1;
  } vec_t;
  vec_t vecs [11];

  task automatic wait_done();
    int n;
    int k;
    n = done_cnt;
    k = 0;
    while (done_cnt == n && k < 2 * FRAME_CLK) begin
      @(negedge clk);
      k++;
    end
    check_int("frame_done_seen", int'(done_cnt != n), 1);
  endtask

  task automatic wait_row(input int r);
    int k;
    repeat (4) @(negedge clk);
    k = 0;
    while (mon_row < r && k < 2 * FRAME_CLK) begin
      @(negedge clk);
      k++;
    end
    check_int("reach_row", int'(mon_row >= r), 1);
  endtask

  task automatic check_frame(input int exp_pat);
    int mism;
    logic [15:0] rgb;
    check_int("frame_pattern", frame_pat, exp_pat);
    check_int("href_rows", rows_seen, H);
    check_int("row_len_errors", bad_rowlen, 0);
    check_int("vsync_pclks", vs_cnt, VS * LINE);
    check_int("blank_data_nonzero", blank_bad, 0);
    for (int r = 0; r < H; r++) begin
      mism = 0;
      for (int c = 0; c < 2 * W; c++) begin
        rgb = model_rgb(exp_pat, c / 2, r);
        if (cap[r][c] !== ((c % 2 == 0) ? rgb[15:8] : rgb[7:0])) mism++;
      end
      check_int($sformatf("row%0d_byte_errors_pat%0d", r, exp_pat), mism, 0);
    end
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].pat == exp_pat) begin
        check_int($sformatf("vec%0d_b0", i), int'(cap[vecs[i].y][2*vecs[i].x]), int'(vecs[i].b0));
        check_int($sformatf("vec%0d_b1", i), int'(cap[vecs[i].y][2*vecs[i].x+1]), int'(vecs[i].b1));
      end
    end
  endtask

  task automatic check_vsync_latency(input string name);
    int k;
    k = 0;
    while (!vsync && k < 6) begin
      @(posedge clk);
      #1;
      k++;
    end
    check_int(name, int'(k <= 2 && vsync), 1);
  endtask

  initial begin
    int rises;
    int hh;
    vecs[0]  = '{0, 5, 3, 8'hF8, 8'h00};
    vecs[1]  = '{1, 9, 7, 8'h00, 8'h1F};
    vecs[2]  = '{2, 0, 0, 8'hFF, 8'hFF};
    vecs[3]  = '{2, 4, 0, 8'hFF, 8'hE0};
    vecs[4]  = '{2, 8, 0, 8'h07, 8'hFF};
    vecs[5]  = '{2, 24, 0, 8'h00, 8'h1F};
    vecs[6]  = '{2, 31, 0, 8'h00, 8'h00};
    vecs[7]  = '{3, 0, 0, 8'hF8, 8'h00};
    vecs[8]  = '{3, 16, 0, 8'h00, 8'h1F};
    vecs[9]  = '{3, 16, 16, 8'hF8, 8'h00};
    vecs[10] = '{3, 0, 16, 8'h00, 8'h1F};

    rst_n = 1'b0; en = 1'b1; pattern = 2'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_int("reset_outputs", int'({pclk, vsync, href, data, frame_done}), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_vsync_latency("vsync_after_reset");

    // Frame A: red; a pattern change mid-frame must not leak in.
    wait_row(H / 2);
    pattern = 2'd2;
    wait_done();
    check_frame(0);

    // Frame B: bars, back-to-back with A.
    wait_row(H / 2);
    pattern = 2'd3;
    wait_done();
    check_int("frame_period_clk", last_done - prev_done, FRAME_CLK);
    check_frame(2);

    // Frame C: checkerboard; then random patterns.
    wait_row(H / 2);
    pattern = 2'($urandom_range(0, 3));
    wait_done();
    check_frame(3);
    for (int f = 0; f < 4; f++) begin
      hh = int'(pattern);
      wait_row(H / 2);
      pattern = (f == 3) ? 2'd0 : 2'($urandom_range(0, 3));
      wait_done();
      check_frame(hh);
    end

    // EN dropped mid-frame: frame completes red, then the source stays idle.
    wait_row(10);
    en = 1'b0;
    pattern = 2'd1;
    wait_done();
    check_frame(0);
    rises = vs_rise;
    hh = href_hi;
    repeat (2 * LINE * 4) @(negedge clk);
    check_int("idle_vsync_rises", vs_rise - rises, 0);
    check_int("idle_href_bytes", href_hi - hh, 0);
    check_int("idle_vsync_level", int'(vsync), 0);

    // Restart, then an asynchronous reset in the middle of the frame.
    @(negedge clk);
    en = 1'b1;
    check_vsync_latency("vsync_after_en");
    wait_row(H / 2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_int("async_reset_outputs", int'({pclk, vsync, href, data, frame_done}), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_int("reset_hold_outputs", int'({pclk, vsync, href, data, frame_done}), 0);
    end
    rst_n = 1'b1;
    check_vsync_latency("vsync_after_midframe_reset");
    wait_done();
    check_frame(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
